// File: rtl/axis_strip_pkg.sv
// Shared state type and keep/byte-count helpers for the AXI-Stream header-strip block.
package axis_strip_pkg;

    // Helpers work on vectors of this width; callers zero-extend and slice.
    localparam int unsigned MaxBytes = 64;

    typedef enum logic [1:0] {
        StIdle,
        StFirst,
        StStream,
        StFlush
    } strip_state_e;

    function automatic int unsigned keep_to_cnt(input logic [MaxBytes-1:0] keep);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < MaxBytes; i++) begin
            if (keep[i]) cnt++;
        end
        return cnt;
    endfunction

    function automatic logic [MaxBytes-1:0] cnt_to_keep(input int unsigned cnt,
                                                        input int unsigned nbytes);
        logic [MaxBytes-1:0] keep;
        keep = '0;
        for (int unsigned i = 0; i < MaxBytes; i++) begin
            if (i < nbytes && i + cnt >= nbytes) keep[i] = 1'b1;
        end
        return keep;
    endfunction

endpackage

// File: rtl/axi_stream_strip_header_if.sv
// Input stream, output stream and strip-count handshakes of axi_stream_strip_header.
interface axi_stream_strip_header_if #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;
    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;
    logic                    valid_strip;
    logic [BYTE_CNT_WD-1:0]  strip_cnt;
    logic                    ready_strip;

    modport slave (
        input  valid_in, data_in, keep_in, last_in, ready_out, valid_strip, strip_cnt,
        output ready_in, valid_out, data_out, keep_out, last_out, ready_strip
    );

    modport master (
        output valid_in, data_in, keep_in, last_in, ready_out, valid_strip, strip_cnt,
        input  ready_in, valid_out, data_out, keep_out, last_out, ready_strip
    );
endinterface

// File: rtl/axis_strip_shift.sv
// Byte merge of the held beat with the next beat, and the left shift used for the flush beat.
module axis_strip_shift #(
    parameter int unsigned DATA_BYTE_WD = 4,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic [8*DATA_BYTE_WD-1:0] i_hold,
    input  logic [8*DATA_BYTE_WD-1:0] i_data,
    input  logic [BYTE_CNT_WD-1:0]    i_strip,
    output logic [8*DATA_BYTE_WD-1:0] o_merge,
    output logic [8*DATA_BYTE_WD-1:0] o_flush
);
    int unsigned w_lsh;
    int unsigned w_rsh;

    // With a zero strip the right shift spans the full width and contributes nothing.
    always_comb begin
        w_lsh   = 8 * 32'(i_strip);
        w_rsh   = 8 * (DATA_BYTE_WD - 32'(i_strip));
        o_flush = i_hold << w_lsh;
        o_merge = o_flush | (i_data >> w_rsh);
    end
endmodule

// File: rtl/axi_stream_strip_header.sv
// Drops S leading bytes per packet and re-packs the payload into full MSB-first beats.
// Optional AXIS_STRIP_KEEP_CHK_EN adds a sticky err_keep flag for malformed keep_in.
module axi_stream_strip_header
    import axis_strip_pkg::*;
#(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    axi_stream_strip_header_if.slave axis
`ifdef AXIS_STRIP_KEEP_CHK_EN
    ,
    output logic                     err_keep
`endif
);
    localparam int unsigned CntWd = BYTE_CNT_WD + 1;
    localparam logic [DATA_BYTE_WD-1:0] KeepFull = {DATA_BYTE_WD{1'b1}};

    strip_state_e            r_state;
    logic [BYTE_CNT_WD-1:0]  r_strip;
    logic [CntWd-1:0]        r_resid;
    logic [DATA_WD-1:0]      r_hold;
    logic [DATA_WD-1:0]      r_data_out;
    logic [DATA_BYTE_WD-1:0] r_keep_out;
    logic                    r_valid_out;
    logic                    r_last_out;
    logic                    r_ready_strip;

    logic [DATA_WD-1:0]      w_merge;
    logic [DATA_WD-1:0]      w_flush;
    logic [MaxBytes-1:0]     w_keep_ext;
    logic [MaxBytes-1:0]     w_tail_keep;
    logic [MaxBytes-1:0]     w_flush_keep;
    logic [DATA_BYTE_WD-1:0] w_tail_k;
    logic [DATA_BYTE_WD-1:0] w_flush_k;
    logic [DATA_WD-1:0]      w_tail_mask;
    logic [DATA_WD-1:0]      w_flush_mask;
    int unsigned             w_k;
    logic                    w_keep_le;
    logic                    w_out_free;
    logic                    w_in_fire;
    logic                    w_strip_fire;
    logic                    w_ready_strip_d;
    logic                    w_unused_keep;

    axis_strip_shift #(
        .DATA_BYTE_WD(DATA_BYTE_WD),
        .BYTE_CNT_WD (BYTE_CNT_WD)
    ) u_shift (
        .i_hold (r_hold),
        .i_data (axis.data_in),
        .i_strip(r_strip),
        .o_merge(w_merge),
        .o_flush(w_flush)
    );

    always_comb begin
        w_keep_ext   = MaxBytes'(axis.keep_in);
        w_k          = keep_to_cnt(w_keep_ext);
        w_keep_le    = w_k <= 32'(r_strip);
        w_tail_keep  = cnt_to_keep(DATA_BYTE_WD - 32'(r_strip) + w_k, DATA_BYTE_WD);
        w_flush_keep = cnt_to_keep(32'(r_resid), DATA_BYTE_WD);
        w_tail_k     = w_tail_keep[DATA_BYTE_WD-1:0];
        w_flush_k    = w_flush_keep[DATA_BYTE_WD-1:0];
        w_tail_mask  = '0;
        w_flush_mask = '0;
        for (int b = 0; b < DATA_BYTE_WD; b++) begin
            w_tail_mask[8*b +: 8]  = {8{w_tail_k[b]}};
            w_flush_mask[8*b +: 8] = {8{w_flush_k[b]}};
        end
    end

    assign w_unused_keep = ^{w_tail_keep[MaxBytes-1:DATA_BYTE_WD],
                             w_flush_keep[MaxBytes-1:DATA_BYTE_WD]};

    assign w_out_free   = !r_valid_out || axis.ready_out;
    assign axis.ready_in = (r_state == StFirst) || (r_state == StStream && w_out_free);
    assign w_in_fire    = axis.valid_in && axis.ready_in;
    assign w_strip_fire = axis.valid_strip && r_ready_strip;

    // Strip count is offered only once idle with the output register drained.
    assign w_ready_strip_d = (r_state == StIdle && !w_strip_fire && w_out_free) ||
                             (r_state == StFirst && w_in_fire && axis.last_in && w_keep_le);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_strip       <= '0;
            r_resid       <= '0;
            r_hold        <= '0;
            r_data_out    <= '0;
            r_keep_out    <= '0;
            r_valid_out   <= 1'b0;
            r_last_out    <= 1'b0;
            r_ready_strip <= 1'b0;
        end else begin
            if (r_valid_out && axis.ready_out) r_valid_out <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_strip_fire) begin
                        r_strip <= axis.strip_cnt;
                        r_state <= StFirst;
                    end
                end
                StFirst: begin
                    if (w_in_fire) begin
                        r_hold <= axis.data_in;
                        if (!axis.last_in) begin
                            r_state <= StStream;
                        end else if (w_keep_le) begin
                            r_state <= StIdle;
                        end else begin
                            r_resid <= CntWd'(w_k - 32'(r_strip));
                            r_state <= StFlush;
                        end
                    end
                end
                StStream: begin
                    if (w_in_fire) begin
                        r_hold      <= axis.data_in;
                        r_valid_out <= 1'b1;
                        if (axis.last_in && w_keep_le) begin
                            r_data_out <= w_merge & w_tail_mask;
                            r_keep_out <= w_tail_k;
                            r_last_out <= 1'b1;
                            r_state    <= StIdle;
                        end else begin
                            r_data_out <= w_merge;
                            r_keep_out <= KeepFull;
                            r_last_out <= 1'b0;
                            if (axis.last_in) begin
                                r_resid <= CntWd'(w_k - 32'(r_strip));
                                r_state <= StFlush;
                            end
                        end
                    end
                end
                StFlush: begin
                    if (w_out_free) begin
                        r_valid_out <= 1'b1;
                        r_data_out  <= w_flush & w_flush_mask;
                        r_keep_out  <= w_flush_k;
                        r_last_out  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
            r_ready_strip <= w_ready_strip_d;
        end
    end

    assign axis.valid_out   = r_valid_out;
    assign axis.data_out    = r_data_out;
    assign axis.keep_out    = r_keep_out;
    assign axis.last_out    = r_last_out;
    assign axis.ready_strip = r_ready_strip;

`ifdef AXIS_STRIP_KEEP_CHK_EN
    logic                r_err_keep;
    logic [MaxBytes-1:0] w_contig_keep;
    logic                w_bad_keep;

    always_comb begin
        w_contig_keep = cnt_to_keep(w_k, DATA_BYTE_WD);
        w_bad_keep    = axis.last_in ? (w_k == 0 || w_keep_ext != w_contig_keep)
                                     : (axis.keep_in != KeepFull);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_keep <= 1'b0;
        end else if (w_in_fire && w_bad_keep) begin
            r_err_keep <= 1'b1;
        end
    end

    assign err_keep = r_err_keep;
`endif
endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed bench for axi_stream_strip_header with W=4; output beats are scoreboarded at negedge.
module tb_axi_stream_strip_header;
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tog_en = 1'b0;
    logic stalled = 1'b0;
    logic [31:0] held = '0;
    int n_chk = 0;
    int n_err = 0;
    beat_t got_q[$];
    beat_t exp_q[$];

    always #5 clk = ~clk;

    axi_stream_strip_header_if #(.DATA_WD(32)) axis ();

`ifdef AXIS_STRIP_KEEP_CHK_EN
    logic err_keep;
`endif

    axi_stream_strip_header #(.DATA_WD(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .axis (axis)
`ifdef AXIS_STRIP_KEEP_CHK_EN
        ,
        .err_keep(err_keep)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Downstream ready: constant 1, or toggling every cycle when tog_en is set.
    always @(posedge clk) begin
        #1;
        axis.ready_out = tog_en ? ~axis.ready_out : 1'b1;
    end

    always @(negedge clk) begin
        if (rst_n && stalled) check("stall_hold", 64'(axis.data_out), 64'(held));
        stalled = rst_n && axis.valid_out && !axis.ready_out;
        held    = axis.data_out;
        if (rst_n && axis.valid_out && axis.ready_out)
            got_q.push_back({axis.data_out, axis.keep_out, axis.last_out});
    end

    task automatic send_strip(input logic [1:0] s);
        logic hs;
        hs = 1'b0;
        axis.valid_strip = 1'b1;
        axis.strip_cnt   = s;
        for (int n = 0; n < 100 && !hs; n++) begin
            @(negedge clk);
            hs = axis.ready_strip;
            @(posedge clk);
            #1;
        end
        axis.valid_strip = 1'b0;
        check("strip_hs", 64'(hs), 64'(1));
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        logic hs;
        hs = 1'b0;
        axis.valid_in = 1'b1;
        axis.data_in  = d;
        axis.keep_in  = k;
        axis.last_in  = l;
        for (int n = 0; n < 100 && !hs; n++) begin
            @(negedge clk);
            hs = axis.ready_in;
            @(posedge clk);
            #1;
        end
        axis.valid_in = 1'b0;
        check("beat_hs", 64'(hs), 64'(1));
    endtask

    task automatic ex(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_q.push_back({d, k, l});
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (n < 200 && !(got_q.size() >= exp_q.size() && axis.ready_strip)) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_cnt"}, 64'(got_q.size()), 64'(exp_q.size()));
        check({tag, "_rstrip"}, 64'(axis.ready_strip), 64'(1));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 64'(axis.valid_out), 64'(0));
        check({tag, "_data"}, 64'(axis.data_out), 64'(0));
        check({tag, "_keep"}, 64'(axis.keep_out), 64'(0));
        check({tag, "_last"}, 64'(axis.last_out), 64'(0));
        check({tag, "_rdy_in"}, 64'(axis.ready_in), 64'(0));
        check({tag, "_rdy_strip"}, 64'(axis.ready_strip), 64'(0));
    endtask

    initial begin
        axis.valid_in    = 1'b0;
        axis.data_in     = '0;
        axis.keep_in     = '0;
        axis.last_in     = 1'b0;
        axis.valid_strip = 1'b0;
        axis.strip_cnt   = '0;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstrip_early", 64'(axis.ready_strip), 64'(0));
        @(posedge clk);
        #1;
        check("rstrip_rise", 64'(axis.ready_strip), 64'(1));

        // S=1, three full beats: two stream beats plus a flush beat.
        send_strip(2'd1);
        send_beat(32'h00112233, 4'hF, 1'b0);
        send_beat(32'h44556677, 4'hF, 1'b0);
        send_beat(32'h8899AABB, 4'hF, 1'b1);
        ex(32'h11223344, 4'hF, 1'b0);
        ex(32'h55667788, 4'hF, 1'b0);
        ex(32'h99AABB00, 4'hE, 1'b1);
        drain("s1");

        // S=2, tail fits in the last stream beat: no flush.
        send_strip(2'd2);
        send_beat(32'hAABBCCDD, 4'hF, 1'b0);
        send_beat(32'h11220000, 4'hC, 1'b1);
        ex(32'hCCDD1122, 4'hF, 1'b1);
        drain("s2");

        // S=0: pass-through delayed by one beat.
        send_strip(2'd0);
        send_beat(32'h01020304, 4'hF, 1'b0);
        send_beat(32'hA0B0C000, 4'hE, 1'b1);
        ex(32'h01020304, 4'hF, 1'b0);
        ex(32'hA0B0C000, 4'hE, 1'b1);
        drain("s0");

        // S=3, single short beat: dropped entirely.
        send_strip(2'd3);
        send_beat(32'hAABB0000, 4'hC, 1'b1);
        drain("drop");

        // S=1 with downstream ready toggling.
        tog_en = 1'b1;
        send_strip(2'd1);
        send_beat(32'h00010203, 4'hF, 1'b0);
        send_beat(32'h04050607, 4'hF, 1'b0);
        send_beat(32'h08090A0B, 4'hF, 1'b0);
        send_beat(32'h0C0D0000, 4'hC, 1'b1);
        ex(32'h01020304, 4'hF, 1'b0);
        ex(32'h05060708, 4'hF, 1'b0);
        ex(32'h090A0B0C, 4'hF, 1'b0);
        ex(32'h0D000000, 4'h8, 1'b1);
        drain("tog");
        tog_en = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Reset in the middle of STREAM, then a clean packet.
        send_strip(2'd1);
        send_beat(32'h00112233, 4'hF, 1'b0);
        send_beat(32'h44556677, 4'hF, 1'b0);
        check("pre_rst_valid", 64'(axis.valid_out), 64'(1));
        check("pre_rst_data", 64'(axis.data_out), 64'(32'h11223344));
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        #2;
        rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        send_strip(2'd2);
        send_beat(32'hAABBCCDD, 4'hF, 1'b0);
        send_beat(32'h11220000, 4'hC, 1'b1);
        ex(32'hCCDD1122, 4'hF, 1'b1);
        drain("post_rst");

`ifdef AXIS_STRIP_KEEP_CHK_EN
        check("err_keep", 64'(err_keep), 64'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/axi_stream_strip_header.md
# axi_stream_strip_header

Removes a per-packet number of leading bytes from an AXI-Stream packet and re-packs the remaining payload into full, MSB-first beats. It sits directly downstream of the header-insertion stage and undoes its operation at the receive end. It produces a stream in the same format it consumes: full beats, with a contiguous MSB-aligned `keep` on the last beat only.

## Interface
Parameters:
- `DATA_WD`, 32, data bus width in bits; must be a multiple of 8.
- `DATA_BYTE_WD`, `DATA_WD/8`, number of bytes per beat.
- `BYTE_CNT_WD`, `$clog2(DATA_BYTE_WD)`, width of the strip count.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `valid_in`  in  1  input beat valid.
- `data_in`  in  `DATA_WD`  input data; byte `DATA_BYTE_WD-1` (MSB) is the first byte on the wire.
- `keep_in`  in  `DATA_BYTE_WD`  byte enables; all ones except on the last beat, where it is MSB-contiguous (1111, 1110, 1100, 1000).
- `last_in`  in  1  last beat of the packet.
- `ready_in`  out  1  input accept.
- `valid_out`  out  1  output beat valid.
- `data_out`  out  `DATA_WD`  re-packed data.
- `keep_out`  out  `DATA_BYTE_WD`  all ones except on the last output beat.
- `last_out`  out  1  last output beat.
- `ready_out`  in  1  downstream accept.
- `valid_strip`  in  1  strip count valid.
- `strip_cnt`  in  `BYTE_CNT_WD`  leading bytes to drop; range 0..`DATA_BYTE_WD-1`.
- `ready_strip`  out  1  strip count accept.

## Operation
- Every handshake is the AXI `valid && ready` transfer. No valid signal depends combinationally on the matching ready.
- Let S = latched strip count, W = `DATA_BYTE_WD`, and k = popcount(`keep_in`).
- **IDLE:** `ready_strip`=1 and `ready_in`=0. A strip handshake latches S and moves to FIRST.
- **FIRST:** `ready_in`=1. The accepted beat goes into the hold register and nothing is output.
  - If `last_in`=1 and k<=S, the packet is dropped entirely: no output, return to IDLE.
  - If `last_in`=1 and k>S, go to FLUSH with k-S residual bytes.
  - Otherwise go to STREAM.
- **STREAM:** `ready_in` = !`valid_out` || `ready_out`. Each accepted beat produces one output beat: the low W-S bytes of hold, concatenated MSB-first with the top S bytes of `data_in`. The new beat then replaces hold.
  - On `last_in` with k<=S: the output is marked last, `keep_out` has (W-S)+k ones from the MSB, and the state returns to IDLE.
  - On `last_in` with k>S: the output beat is full and not last, and the state moves to FLUSH.
- **FLUSH:** `ready_in`=0. The block emits one last beat: hold shifted left by S bytes, `keep_out` = k-S ones from the MSB, unused bytes zero. It then returns to IDLE.
- S=0 needs no special case. The rules above reduce to a one-beat delay, plus a FLUSH beat that carries the last input beat unchanged.
- Bytes not covered by `keep_out` are driven to zero.
- Reset in the middle of a packet abandons it. The upstream side is responsible for restarting on a packet boundary.

## Timing
- Reset values: `valid_out`=0, `data_out`=0, `keep_out`=0, `last_out`=0, `ready_in`=0, `ready_strip`=0. State is IDLE and hold=0.
- `ready_strip` rises 1 cycle after reset deasserts.
- All outputs are registered.
- The first output beat appears 1 cycle after the handshake of the second input beat, or of the FLUSH beat for a single-beat packet.
- Throughput is 1 beat per cycle in STREAM. An N-beat packet with a residual costs one extra FLUSH cycle.
- The output register holds its value while `valid_out && !ready_out`.
- The next strip handshake is accepted on the cycle after the last output beat is accepted. There is no cross-packet overlap.

## Configuration
- `AXIS_STRIP_KEEP_CHK_EN`:
  - **Defined:** the block adds an output port `err_keep` (1 bit, reset 0). It sets sticky on any accepted input beat where either `keep_in` is not all ones without `last_in`, or `keep_in` is non-contiguous/zero with `last_in`. It clears only on reset. The offending beat is still processed, using its popcount.
  - **Undefined:** the port and its check logic are absent.

## Structure
- Shared package `axis_strip_pkg` holds:
  - the state enum (IDLE, FIRST, STREAM, FLUSH);
  - the function keep→byte count;
  - the function count→MSB-contiguous keep.
- One sub-module, `axis_strip_shift`, holds the combinational hold/new byte merge and shift, parameterised by `DATA_BYTE_WD`.
- All widths follow `DATA_BYTE_WD`. No constants hardwired for 4 bytes.

## Test plan
All scenarios use W=4.
- S=1, packet of 3 full beats 0x00112233, 0x44556677, 0x8899AABB → 0x11223344, 0x55667788, then 0x99AABB00 with keep 1110, last.
- S=2, 2 beats 0xAABBCCDD, 0x11220000 with keep 1100 → single beat 0xCCDD1122, keep 1111, last. No FLUSH.
- S=0, 2 beats → identical data delayed by 1 beat. Last keep is preserved.
- S=3, single beat 0xAABB0000 with keep 1100 → no output. `ready_strip` returns to 1.
- S=1, `ready_out` toggling 1010… during a 4-beat packet → no beat lost or duplicated, and `data_out` stays stable while stalled.
- Reset asserted during STREAM → all outputs 0 immediately. The next packet after reset is processed correctly.
